// File: rtl/p405s_dcu_tag_ctl_pkg.sv
// Shared constants, FSM encoding and parity helper for the DCU tag array controller.
package p405s_dcu_tag_ctl_pkg;

  localparam int SETS   = 256;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 48;
  localparam logic [DATA_W-1:0] INV_MASK = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INV   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Even parity over the data bits, excluding the parity bit itself.
  function automatic logic par_even(input logic [DATA_W-2:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/p405s_dcu_tag_inv_seq.sv
// Flash-invalidate walker: set counter, busy flag, terminal-count detect and done pulse.
module p405s_dcu_tag_inv_seq #(
  parameter int SETS   = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              issue,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              term,
  output logic              done
);

  localparam logic [ADDR_W:0] CNT_END = (ADDR_W+1)'(SETS);

  // cnt holds the next set to issue; one extra bit lets it park at SETS without wrapping.
  logic [ADDR_W:0] cnt;

  assign term  = busy && (cnt == CNT_END);
  assign issue = start || (busy && (cnt < CNT_END));
  assign addr  = start ? '0 : cnt[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // set 0 is issued on the start edge itself
        cnt  <= (ADDR_W+1)'(1);
        busy <= 1'b1;
      end else if (term) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else if (busy && (cnt < CNT_END)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/p405s_dcu_tag_ctl.sv
// Requester-side controller for the DCU tag array: request pipe, flash invalidate, array drive.
// Optional parity protection on the top data bit: define P405S_DCU_TAG_PARITY_EN.
module p405s_dcu_tag_ctl
  import p405s_dcu_tag_ctl_pkg::*;
#(
  parameter int                SETS_P   = SETS,
  parameter int                ADDR_W_P = ADDR_W,
  parameter int                DATA_W_P = DATA_W,
  parameter logic [DATA_W-1:0] INV_M    = INV_MASK
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W_P-1:0] req_addr,
  input  logic [DATA_W_P-1:0] req_wdata,
  input  logic [DATA_W_P-1:0] req_wmask,
  output logic                resp_valid,
  output logic [DATA_W_P-1:0] resp_data,
  input  logic                inv_start,
  output logic                inv_busy,
  output logic                inv_done,
  output logic                tag_CEN,
  output logic [DATA_W_P-1:0] tag_WEN,
  output logic [ADDR_W_P-1:0] tag_A,
  output logic [DATA_W_P-1:0] tag_D,
  input  logic [DATA_W_P-1:0] tag_Q
`ifdef P405S_DCU_TAG_PARITY_EN
  ,output logic               par_err
`endif
);

  state_e state, nxt;

  logic                s1_vld, s1_rd;
  logic                acc, inv_go;
  logic                inv_issue, inv_term;
  logic [ADDR_W_P-1:0] inv_addr;
  logic [DATA_W_P-1:0] wen_w, wd_w;

  p405s_dcu_tag_inv_seq #(
    .SETS   (SETS_P),
    .ADDR_W (ADDR_W_P)
  ) u_inv_seq (
    .clk   (CLK),
    .rst   (RST),
    .start (inv_go),
    .issue (inv_issue),
    .addr  (inv_addr),
    .busy  (inv_busy),
    .term  (inv_term),
    .done  (inv_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_INV;
    else     state <= nxt;
  end

  always_comb begin
    nxt    = state;
    inv_go = 1'b0;
    case (state)
      ST_INV:   if (inv_term) nxt = ST_IDLE;
      ST_IDLE:
        if (inv_start) begin
          if (s1_vld) nxt = ST_DRAIN;
          else begin
            nxt    = ST_INV;
            inv_go = 1'b1;
          end
        end
      ST_DRAIN:
        if (!s1_vld) begin
          nxt    = ST_INV;
          inv_go = 1'b1;
        end
      default:  nxt = ST_INV;
    endcase
  end

  // An invalidate request in the same cycle takes priority over any request.
  assign req_ready = (state == ST_IDLE) && !inv_start;
  assign acc       = req_valid && req_ready;

  always_comb begin
    wen_w = ~req_wmask;
    wd_w  = req_wdata;
`ifdef P405S_DCU_TAG_PARITY_EN
    if (|req_wmask) begin
      wen_w[DATA_W_P-1] = 1'b0;
      wd_w[DATA_W_P-1]  = par_even(req_wdata[DATA_W_P-2:0]);
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_CEN <= 1'b1;
      tag_WEN <= '1;
      tag_A   <= '0;
      tag_D   <= '0;
      s1_vld  <= 1'b0;
      s1_rd   <= 1'b0;
    end else begin
      tag_CEN <= 1'b1;
      tag_WEN <= '1;
      tag_D   <= '0;
      s1_vld  <= 1'b0;
      s1_rd   <= 1'b0;
      if (inv_issue) begin
        tag_CEN <= 1'b0;
        tag_WEN <= ~INV_M;
        tag_A   <= inv_addr;
      end else if (acc) begin
        tag_CEN <= 1'b0;
        tag_A   <= req_addr;
        s1_vld  <= 1'b1;
        s1_rd   <= !req_write;
        if (req_write) begin
          tag_WEN <= wen_w;
          tag_D   <= wd_w;
        end
      end
    end
  end

  // tag_Q settles from tag_A during the access cycle and is captured at its end.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= s1_rd;
      if (s1_rd) resp_data <= tag_Q;
    end
  end

`ifdef P405S_DCU_TAG_PARITY_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) par_err <= 1'b0;
    else     par_err <= s1_rd && (^tag_Q);
  end
`endif

endmodule

// File: tb/tb_p405s_dcu_tag_ctl.sv
// Scoreboard bench for p405s_dcu_tag_ctl with a behavioural 256x48 tag array model.
module tb_p405s_dcu_tag_ctl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr  = '0;
  logic [47:0] req_wdata = '0;
  logic [47:0] req_wmask = '0;
  logic        resp_valid;
  logic [47:0] resp_data;
  logic        inv_start = 1'b0;
  logic        inv_busy, inv_done;
  logic        tag_CEN;
  logic [47:0] tag_WEN, tag_D, tag_Q;
  logic [7:0]  tag_A;
`ifdef P405S_DCU_TAG_PARITY_EN
  logic        par_err;
`endif

  p405s_dcu_tag_ctl dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .inv_start  (inv_start),
    .inv_busy   (inv_busy),
    .inv_done   (inv_done),
    .tag_CEN    (tag_CEN),
    .tag_WEN    (tag_WEN),
    .tag_A      (tag_A),
    .tag_D      (tag_D),
    .tag_Q      (tag_Q)
`ifdef P405S_DCU_TAG_PARITY_EN
    ,.par_err   (par_err)
`endif
  );

  always #5 CLK = ~CLK;

  // array macro: combinational read, falling-edge bit-masked write
  logic [47:0] mem [256];
  assign tag_Q = mem[tag_A];
  always @(negedge CLK)
    if (!tag_CEN) mem[tag_A] <= (mem[tag_A] & tag_WEN) | (tag_D & ~tag_WEN);

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [47:0] d;
    int          c;
  } exp_t;
  exp_t        sb[$];
  logic [47:0] shadow [256];

  always @(negedge CLK) begin
    if (!RST && resp_valid) begin
      if (sb.size() == 0) chk("resp_unexpected", 64'(resp_valid), 64'(0));
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", 64'(resp_data), 64'(e.d));
        chk("resp_latency", 64'(cyc), 64'(e.c));
      end
    end
  end

  // Call right after a negedge; returns on the following negedge with req_valid low.
  task automatic send(input bit w, input logic [7:0] a, input logic [47:0] d, input logic [47:0] m);
    exp_t e;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    #1;
    chk("req_ready", 64'(req_ready), 64'(1));
    if (w) shadow[a] = (shadow[a] & ~m) | (d & m);
    else begin
      e.d = shadow[a];
      e.c = cyc + 2;
      sb.push_back(e);
    end
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  // Call just before the edge that issues set 0.
  task automatic walk_check(input bit poke);
    for (int k = 0; k < 256; k++) begin
      @(posedge CLK); #1;
      if (k == 0) inv_start = 1'b0;
      if (poke && k == 50) inv_start = 1'b1;
      if (poke && k == 51) inv_start = 1'b0;
      chk("walk", {54'd0, tag_CEN, inv_busy, tag_A}, {54'd0, 1'b0, 1'b1, 8'(k)});
      if (k == 0) chk("walk_wen", 64'(tag_WEN), 64'(0));
    end
    @(posedge CLK); #1;
    chk("done_pulse", {60'd0, inv_done, inv_busy, req_ready, tag_CEN}, {60'd0, 4'b1011});
    @(posedge CLK); #1;
    chk("done_clear", {62'd0, inv_done, inv_busy}, 64'(0));
    for (int i = 0; i < 256; i++) shadow[i] = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {57'd0, tag_CEN, req_ready, resp_valid, inv_busy, inv_done, 2'b00},
        {57'd0, 5'b10010, 2'b00});
    chk({tag, "_wen"}, 64'(tag_WEN), 64'(48'hFFFF_FFFF_FFFF));
    chk({tag, "_a_d"}, {tag_A, 8'd0, tag_D}, 64'(0));
    chk({tag, "_resp"}, 64'(resp_data), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = {16'($urandom), 32'($urandom)};
      shadow[i] = '0;
    end
    repeat (3) @(negedge CLK);
    chk_reset("reset");
    RST = 1'b0;
    walk_check(1'b0);

    // write / read / masked write
    @(negedge CLK);
    send(1'b1, 8'h3C, 48'hA5A5_0000_1234, 48'hFFFF_FFFF_FFFF);
    send(1'b0, 8'h3C, 48'h0, 48'h0);
    send(1'b1, 8'h3C, 48'h0, 48'h0000_0000_FFFF);
    send(1'b0, 8'h3C, 48'h0, 48'h0);
    chk("shadow_masked", 64'(shadow[8'h3C]), 64'(48'hA5A5_0000_0000));
    send(1'b1, 8'h01, 48'h1357_9BDF_0246, 48'hFFFF_0000_FFFF);
    // back-to-back reads
    send(1'b0, 8'h00, 48'h0, 48'h0);
    send(1'b0, 8'h01, 48'h0, 48'h0);
    send(1'b0, 8'hFF, 48'h0, 48'h0);
    repeat (4) @(negedge CLK);

    // invalidate with a read in flight; a request alongside inv_start is refused
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h3C;
    #1;
    chk("drain_rd_ready", 64'(req_ready), 64'(1));
    sb.push_back('{d: shadow[8'h3C], c: cyc + 2});
    @(negedge CLK);
    req_addr  = 8'h10;
    inv_start = 1'b1;
    #1;
    chk("inv_wins_ready", 64'(req_ready), 64'(0));
    @(negedge CLK);
    req_valid = 1'b0;
    chk("drain_busy", 64'(inv_busy), 64'(0));
    walk_check(1'b1);
    @(negedge CLK);
    send(1'b0, 8'h3C, 48'h0, 48'h0);
    repeat (4) @(negedge CLK);

    // reset in the middle of a walk
    inv_start = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      @(posedge CLK); #1;
      if (k == 0) inv_start = 1'b0;
    end
    chk("abort_at_100", 64'(tag_A), 64'(100));
    #2 RST = 1'b1;
    #1 chk_reset("abort");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    walk_check(1'b0);
    @(negedge CLK);
    send(1'b1, 8'h80, 48'h0F0F_F0F0_1111, 48'hFFFF_FFFF_FFFF);
    send(1'b0, 8'h80, 48'h0, 48'h0);
    send(1'b0, 8'h3C, 48'h0, 48'h0);
    repeat (4) @(negedge CLK);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
    $finish;
  end

endmodule
